// File: rtl/sap_controller.sv
// sap_controller: T1-T6 ring sequencer and control-word decoder for the 8-bit bus machine
//   clk, clrbar (sync active-low reset), opcode[3:0] (IR upper nibble, valid T4-T6)
//   t_state[5:0] one-hot ring; cp, epbar, lmbar, cebar, libar, eibar, labar, ea,
//   add_subbar, enablebar, lbbar, lobar control word; hlt halted flag; instr_count[7:0]
module sap_controller (
  input  logic       clk,
  input  logic       clrbar,
  input  logic [3:0] opcode,
  output logic [5:0] t_state,
  output logic       cp,
  output logic       epbar,
  output logic       lmbar,
  output logic       cebar,
  output logic       libar,
  output logic       eibar,
  output logic       labar,
  output logic       ea,
  output logic       add_subbar,
  output logic       enablebar,
  output logic       lbbar,
  output logic       lobar,
  output logic       hlt,
  output logic [7:0] instr_count
);
  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } state_t;
  localparam logic [3:0] LDA = 4'b0000;
  localparam logic [3:0] ADD = 4'b0001;
  localparam logic [3:0] SUB = 4'b0010;
  localparam logic [3:0] OUT = 4'b1110;
  localparam logic [3:0] HLT = 4'b1111;
  state_t state, state_n;
  logic   halted, halt_n;
  logic   mem_op, alu_op, is_hlt;
  assign mem_op  = opcode == LDA || opcode == ADD || opcode == SUB;
  assign alu_op  = opcode == ADD || opcode == SUB;
  assign is_hlt  = opcode == HLT;
  assign t_state = state;
  // once halted the ring parks in T4 until reset
  always_comb begin
    state_n = state;
    halt_n  = halted;
    if (!halted) begin
      case (state)
        T1:      state_n = T2;
        T2:      state_n = T3;
        T3:      state_n = T4;
        T4:      state_n = is_hlt ? T4 : T5;
        T5:      state_n = T6;
        default: state_n = T1;
      endcase
      halt_n = state == T4 && is_hlt;
    end
  end
  always_ff @(posedge clk) begin
    if (!clrbar) begin
      state       <= T1;
      halted      <= 1'b0;
      instr_count <= 8'd0;
    end else begin
      state  <= state_n;
      halted <= halt_n;
      if (state == T6) instr_count <= instr_count + 8'd1;
    end
  end
  // decode only while running; reset low or halted yields the inactive word
  always_comb begin
    cp         = 1'b0;
    epbar      = 1'b1;
    lmbar      = 1'b1;
    cebar      = 1'b1;
    libar      = 1'b1;
    eibar      = 1'b1;
    labar      = 1'b1;
    ea         = 1'b0;
    add_subbar = 1'b1;
    enablebar  = 1'b1;
    lbbar      = 1'b1;
    lobar      = 1'b1;
    hlt        = clrbar && halted;
    if (clrbar && !halted) begin
      case (state)
        T1: begin
          epbar = 1'b0;
          lmbar = 1'b0;
        end
        T2: cp = 1'b1;
        T3: begin
          cebar = 1'b0;
          libar = 1'b0;
        end
        T4: begin
          eibar = !mem_op;
          lmbar = !mem_op;
          ea    = opcode == OUT;
          lobar = opcode != OUT;
          hlt   = is_hlt;
        end
        T5: begin
          cebar = !mem_op;
          labar = opcode != LDA;
          lbbar = !alu_op;
        end
        T6: begin
          enablebar  = !alu_op;
          labar      = !alu_op;
          add_subbar = opcode != SUB;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sap_controller.sv
// tb_sap_controller: directed self-checking bench for sap_controller
module tb_sap_controller;
  logic       clk = 1'b0;
  logic       clrbar = 1'b0;
  logic [3:0] opcode = 4'b0000;
  logic [5:0] t_state;
  logic       cp, epbar, lmbar, cebar, libar, eibar, labar, ea;
  logic       add_subbar, enablebar, lbbar, lobar, hlt;
  logic [7:0] instr_count;
  logic [7:0] exp_cnt = 8'd0;
  int checks = 0;
  int fails = 0;
  localparam logic [12:0] IDLE = 13'b0111111011110;
  localparam logic [12:0] CP = 13'h1000, EP = 13'h0800, LM = 13'h0400, CE = 13'h0200;
  localparam logic [12:0] LI = 13'h0100, EI = 13'h0080, LA = 13'h0040, EA = 13'h0020;
  localparam logic [12:0] AS = 13'h0010, EN = 13'h0008, LB = 13'h0004, LO = 13'h0002;
  localparam logic [12:0] HL = 13'h0001;
  logic [12:0] cw;
  assign cw = {cp, epbar, lmbar, cebar, libar, eibar, labar, ea, add_subbar, enablebar, lbbar, lobar, hlt};
  sap_controller dut (
    .clk(clk), .clrbar(clrbar), .opcode(opcode), .t_state(t_state),
    .cp(cp), .epbar(epbar), .lmbar(lmbar), .cebar(cebar), .libar(libar),
    .eibar(eibar), .labar(labar), .ea(ea), .add_subbar(add_subbar),
    .enablebar(enablebar), .lbbar(lbbar), .lobar(lobar), .hlt(hlt),
    .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  // expected control word: inactive word with the departing bits flipped
  function automatic logic [12:0] exp_cw(input logic [3:0] op, input int t);
    logic [12:0] m;
    logic mem, alu;
    mem = op == 4'h0 || op == 4'h1 || op == 4'h2;
    alu = op == 4'h1 || op == 4'h2;
    m = 13'h0;
    case (t)
      1: m = EP | LM;
      2: m = CP;
      3: m = CE | LI;
      4: m = mem ? (EI | LM) : op == 4'hE ? (EA | LO) : op == 4'hF ? HL : 13'h0;
      5: m = op == 4'h0 ? (CE | LA) : alu ? (CE | LB) : 13'h0;
      6: m = op == 4'h1 ? (EN | LA) : op == 4'h2 ? (EN | LA | AS) : 13'h0;
      default: m = 13'h0;
    endcase
    return IDLE ^ m;
  endfunction
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    clrbar = 1'b0;
    step();
    clrbar = 1'b1;
    #1;
    exp_cnt = 8'd0;
  endtask
  // one instruction from T1; HLT stops after checking T4 without stepping
  task automatic run_instr(input logic [3:0] op, input string name);
    opcode = op;
    #1;
    for (int t = 1; t <= 6; t++) begin
      checks++;
      if (t_state !== 6'(1 << (t - 1))) begin
        fails++;
        $display("FAIL %s t_state T%0d: got %b want %b", name, t, t_state, 6'(1 << (t - 1)));
      end
      checks++;
      if (cw !== exp_cw(op, t)) begin
        fails++;
        $display("FAIL %s cw T%0d: got %b want %b", name, t, cw, exp_cw(op, t));
      end
      if (op == 4'hF && t == 4) return;
      step();
    end
    exp_cnt = exp_cnt + 8'd1;
    checks++;
    if (instr_count !== exp_cnt) begin
      fails++;
      $display("FAIL %s instr_count: got %0d want %0d", name, instr_count, exp_cnt);
    end
  endtask
  task automatic test_reset();
    clrbar = 1'b0;
    step();
    step();
    checks++;
    if (t_state !== 6'b000001 || instr_count !== 8'd0) begin
      fails++;
      $display("FAIL reset_state: got t_state=%b cnt=%0d want 000001/0", t_state, instr_count);
    end
    checks++;
    if (cw !== IDLE) begin
      fails++;
      $display("FAIL reset_cw: got %b want %b", cw, IDLE);
    end
    clrbar = 1'b1;
    #1;
    checks++;
    if (cw !== (IDLE ^ (EP | LM))) begin
      fails++;
      $display("FAIL reset_release_t1: got %b want %b", cw, IDLE ^ (EP | LM));
    end
  endtask
  task automatic test_lda();
    run_instr(4'h0, "lda");
    checks++;
    if (t_state !== 6'b000001) begin
      fails++;
      $display("FAIL lda_wrap_t1: got %b want 000001", t_state);
    end
  endtask
  task automatic test_back_to_back();
    do_reset();
    run_instr(4'h1, "add");
    run_instr(4'h2, "sub");
    checks++;
    if (instr_count !== 8'd2) begin
      fails++;
      $display("FAIL add_sub_count: got %0d want 2", instr_count);
    end
  endtask
  task automatic test_out_nop();
    run_instr(4'hE, "out");
    run_instr(4'h5, "nop");
  endtask
  task automatic test_hlt();
    run_instr(4'hF, "hlt");
    for (int i = 0; i < 22; i++) begin
      step();
      checks++;
      if (t_state !== 6'b001000 || cw !== (IDLE ^ HL) || instr_count !== exp_cnt) begin
        fails++;
        $display("FAIL halted_hold %0d: got ts=%b cw=%b cnt=%0d want 001000/%b/%0d",
                 i, t_state, cw, instr_count, IDLE ^ HL, exp_cnt);
      end
    end
    clrbar = 1'b0;
    #1;
    checks++;
    if (cw !== IDLE) begin
      fails++;
      $display("FAIL halted_reset_low: got %b want %b", cw, IDLE);
    end
    step();
    clrbar = 1'b1;
    #1;
    exp_cnt = 8'd0;
    checks++;
    if (t_state !== 6'b000001 || cw !== (IDLE ^ (EP | LM)) || instr_count !== 8'd0) begin
      fails++;
      $display("FAIL halt_exit: got ts=%b cw=%b cnt=%0d want 000001/%b/0", t_state, cw, instr_count, IDLE ^ (EP | LM));
    end
  endtask
  task automatic test_mid_reset();
    do_reset();
    opcode = 4'h1;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (t_state !== 6'b010000 || cw !== (IDLE ^ (CE | LB))) begin
      fails++;
      $display("FAIL mid_t5: got ts=%b cw=%b want 010000/%b", t_state, cw, IDLE ^ (CE | LB));
    end
    clrbar = 1'b0;
    #1;
    checks++;
    if (lbbar !== 1'b1 || cw !== IDLE) begin
      fails++;
      $display("FAIL mid_reset_low: got lbbar=%b cw=%b want 1/%b", lbbar, cw, IDLE);
    end
    step();
    clrbar = 1'b1;
    #1;
    checks++;
    if (t_state !== 6'b000001 || instr_count !== 8'd0) begin
      fails++;
      $display("FAIL mid_reset_after: got ts=%b cnt=%0d want 000001/0", t_state, instr_count);
    end
    exp_cnt = 8'd0;
  endtask
  task automatic test_wrap();
    do_reset();
    opcode = 4'h5;
    for (int i = 0; i < 255 * 6; i++) step();
    checks++;
    if (instr_count !== 8'hFF) begin
      fails++;
      $display("FAIL wrap_255: got %0d want 255", instr_count);
    end
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (instr_count !== 8'h00 || t_state !== 6'b000001) begin
      fails++;
      $display("FAIL wrap_0: got cnt=%0d ts=%b want 0/000001", instr_count, t_state);
    end
    exp_cnt = 8'd0;
  endtask
  task automatic test_random();
    logic [3:0] ops [0:7];
    logic [3:0] op;
    ops = '{4'h0, 4'h1, 4'h2, 4'hE, 4'h5, 4'h1, 4'h2, 4'h9};
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 7)];
      opcode = op;
      #1;
      for (int t = 1; t <= 6; t++) begin
        checks++;
        if ($countones({~epbar, ~cebar, ~eibar, ~enablebar, ea}) > 1) begin
          fails++;
          $display("FAIL bus_exclusive op=%h T%0d: got cw=%b", op, t, cw);
        end
        checks++;
        if (cw !== exp_cw(op, t) || t_state !== 6'(1 << (t - 1))) begin
          fails++;
          $display("FAIL random op=%h T%0d: got cw=%b ts=%b want %b", op, t, cw, t_state, exp_cw(op, t));
        end
        step();
      end
      exp_cnt = exp_cnt + 8'd1;
    end
    checks++;
    if (instr_count !== exp_cnt) begin
      fails++;
      $display("FAIL random_count: got %0d want %0d", instr_count, exp_cnt);
    end
  endtask
  initial begin
    test_reset();
    test_lda();
    test_back_to_back();
    test_out_nop();
    test_hlt();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
